// File: rtl/fetch_issue_unit_if.sv
// rtl/fetch_issue_unit_if.sv - imem read, decode handshake and redirect signals of the fetch/issue front end
interface fetch_issue_unit_if #(
    parameter int INSTR_W = 16,
    parameter int PC_W    = 10
);
    logic               imem_rd_en;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               dec_valid;
    logic               dec_ready;
    logic [INSTR_W-1:0] dec_instr;
    logic [8:0]         dec_opcode;
    logic [PC_W-1:0]    dec_pc;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               halted;

    modport master (
        output imem_rd_en, imem_addr, dec_valid, dec_instr, dec_opcode, dec_pc, halted,
        input  imem_rdata, dec_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_rd_en, imem_addr, dec_valid, dec_instr, dec_opcode, dec_pc, halted,
        output imem_rdata, dec_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_issue_unit.sv
// rtl/fetch_issue_unit.sv - PC, 1-cycle imem fetch, 2-entry issue FIFO with redirect flush
// Optional HLT stop: define HALT_DETECT_EN.
module fetch_issue_unit #(
    parameter int         INSTR_W  = 16,
    parameter int         PC_W     = 10,
    parameter int         RESET_PC = 0,
    parameter logic [8:0] NOP_OP   = 9'b101
) (
    input  logic clk,
    input  logic rst_n,
    fetch_issue_unit_if.master bus
);
    localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);

    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    r_req_pc;
    logic               r_req_epoch;
    logic               r_epoch;
    logic               r_inflight;
    logic [1:0]         r_count;
    logic [INSTR_W-1:0] r_instr0;
    logic [INSTR_W-1:0] r_instr1;
    logic [PC_W-1:0]    r_ipc0;
    logic [PC_W-1:0]    r_ipc1;

    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    logic               w_halted;
    logic [2:0]         w_occ;

    assign w_valid = (r_count != 2'd0);
    assign w_pop   = w_valid & bus.dec_ready;

    // Every in-flight read owns a FIFO slot, so the FIFO can never overflow.
    assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = rst_n & ~bus.redirect_valid & ~w_halted & (w_occ < 3'd2);

    // Returns from a stale epoch, or arriving after a halt, are discarded.
    assign w_push  = r_inflight & (r_req_epoch == r_epoch) & ~bus.redirect_valid & ~w_halted;

`ifdef HALT_DETECT_EN
    logic r_halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halted <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_halted <= 1'b0;
        end else if (w_push && (bus.imem_rdata[INSTR_W-1 -: 9] == 9'h1FF)) begin
            r_halted <= 1'b1;
        end
    end

    assign w_halted = r_halted;
`else
    assign w_halted = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC_V;
            r_req_pc    <= '0;
            r_req_epoch <= 1'b0;
            r_epoch     <= 1'b0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_req_pc    <= r_pc;
                r_req_epoch <= r_epoch;
                r_pc        <= r_pc + PC_W'(1);
            end
            if (bus.redirect_valid) begin
                r_pc    <= bus.redirect_pc;
                r_epoch <= ~r_epoch;
            end
        end
    end

    // Shift-register FIFO: entry 0 is always the head shown to decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= 2'd0;
            r_instr0 <= '0;
            r_instr1 <= '0;
            r_ipc0   <= '0;
            r_ipc1   <= '0;
        end else if (bus.redirect_valid) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b01: begin
                    r_instr0 <= r_instr1;
                    r_ipc0   <= r_ipc1;
                    r_count  <= r_count - 2'd1;
                end
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_instr0 <= bus.imem_rdata;
                        r_ipc0   <= r_req_pc;
                    end else begin
                        r_instr1 <= bus.imem_rdata;
                        r_ipc1   <= r_req_pc;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_instr0 <= bus.imem_rdata;
                        r_ipc0   <= r_req_pc;
                    end else begin
                        r_instr0 <= r_instr1;
                        r_ipc0   <= r_ipc1;
                        r_instr1 <= bus.imem_rdata;
                        r_ipc1   <= r_req_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.imem_rd_en = w_issue;
    assign bus.imem_addr  = r_pc;
    assign bus.dec_valid  = w_valid;
    assign bus.dec_instr  = w_valid ? r_instr0 : '0;
    assign bus.dec_opcode = w_valid ? r_instr0[INSTR_W-1 -: 9] : NOP_OP;
    assign bus.dec_pc     = w_valid ? r_ipc0 : '0;
    assign bus.halted     = w_halted;
endmodule

// File: tb/tb_fetch_issue_unit.sv
// tb/tb_fetch_issue_unit.sv - directed stimulus with a program-order decode model for fetch_issue_unit
module tb_fetch_issue_unit;
    localparam logic [8:0] NOP = 9'b101;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [15:0] mem [0:1023];

    fetch_issue_unit_if #(.INSTR_W(16), .PC_W(10)) bus ();

    fetch_issue_unit #(.INSTR_W(16), .PC_W(10), .RESET_PC(0), .NOP_OP(9'b101)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.imem_rd_en) bus.imem_rdata <= mem[bus.imem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: decode must see memory words in program order from the last reset/redirect target.
    logic [9:0]  exp_pc = 10'd0;
    logic        exp_halt = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_instr;
    logic [9:0]  prev_pc;
    logic [15:0] word;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_rd_en", 32'(bus.imem_rd_en), 32'd0);
            chk("rst_valid", 32'(bus.dec_valid), 32'd0);
            chk("rst_instr", 32'(bus.dec_instr), 32'd0);
            chk("rst_opcode", 32'(bus.dec_opcode), 32'(NOP));
            chk("rst_pc", 32'(bus.dec_pc), 32'd0);
            chk("rst_halted", 32'(bus.halted), 32'd0);
            exp_pc = 10'd0;
            exp_halt = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_instr", 32'(bus.dec_instr), 32'(prev_instr));
                chk("stall_hold_pc", 32'(bus.dec_pc), 32'(prev_pc));
            end
            if (bus.redirect_valid) chk("redirect_no_rd", 32'(bus.imem_rd_en), 32'd0);
            word = mem[exp_pc];
            if (bus.dec_valid) begin
                chk("model_pc", 32'(bus.dec_pc), 32'(exp_pc));
                chk("model_instr", 32'(bus.dec_instr), 32'(word));
                chk("model_opcode", 32'(bus.dec_opcode), 32'(word[15:7]));
`ifdef HALT_DETECT_EN
                if (word[15:7] == 9'h1FF) exp_halt = 1'b1;
`endif
            end else begin
                chk("idle_opcode", 32'(bus.dec_opcode), 32'(NOP));
                chk("idle_instr", 32'(bus.dec_instr), 32'd0);
            end
`ifdef HALT_DETECT_EN
            if (exp_halt) begin
                chk("halt_flag", 32'(bus.halted), 32'd1);
                chk("halt_no_rd", 32'(bus.imem_rd_en), 32'd0);
            end
`else
            chk("halted_tied0", 32'(bus.halted), 32'd0);
`endif
            if (bus.dec_valid && bus.dec_ready) exp_pc = exp_pc + 10'd1;
            if (bus.redirect_valid) begin
                exp_pc = bus.redirect_pc;
                exp_halt = 1'b0;
            end
            prev_stall = bus.dec_valid & ~bus.dec_ready & ~bus.redirect_valid;
            prev_instr = bus.dec_instr;
            prev_pc = bus.dec_pc;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        rst_n = 1'b0;
        bus.dec_ready = ready;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 10'd0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    logic [9:0] rd_addr [0:5];
    logic       rd_en   [0:5];
    logic [8:0] opc     [0:5];
    logic [9:0] pc_seq  [0:4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = {9'((i % 400) + 1), 7'(i)};
        bus.imem_rdata = 16'd0;

        // Reset and streaming
        do_reset(1'b1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rd_en[c] = bus.imem_rd_en;
            rd_addr[c] = bus.imem_addr;
            opc[c] = bus.dec_opcode;
            next_cycle();
        end
        for (int c = 0; c < 4; c++) begin
            chk("t1_rd_en", 32'(rd_en[c]), 32'd1);
            chk("t1_rd_addr", 32'(rd_addr[c]), 32'(c));
        end
        chk("t1_op_c0", 32'(opc[0]), 32'h5);
        chk("t1_op_c1", 32'(opc[1]), 32'h5);
        for (int c = 2; c < 6; c++) chk("t1_opcode", 32'(opc[c]), 32'(c - 1));

        // Stall for five cycles after the first valid word
        do_reset(1'b0);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 6) begin
                chk("t2_valid", 32'(bus.dec_valid), 32'd1);
                chk("t2_opcode", 32'(bus.dec_opcode), 32'd1);
                chk("t2_pc", 32'(bus.dec_pc), 32'd0);
                chk("t2_rd_en", 32'(bus.imem_rd_en), 32'd0);
            end
            next_cycle();
        end
        bus.dec_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t2_release_op", 32'(bus.dec_opcode), 32'(c + 1));
            next_cycle();
        end

        // Redirect while the read of 0x02 is in flight
        do_reset(1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 2) chk("t3_rd_addr2", 32'({bus.imem_rd_en, bus.imem_addr}), 32'h402);
            next_cycle();
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 10'h040;
        @(negedge clk);
        chk("t3_rd_en_redirect", 32'(bus.imem_rd_en), 32'd0);
        next_cycle();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("t3_rd_addr40", 32'({bus.imem_rd_en, bus.imem_addr}), 32'h440);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("t3_dec_pc", 32'({bus.dec_valid, bus.dec_pc}), 32'h440);
        next_cycle();

        // Redirect to the last address; PC wraps to zero
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 10'h3FF;
        next_cycle();
        bus.redirect_valid = 1'b0;
        next_cycle();
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            pc_seq[c] = bus.dec_valid ? bus.dec_pc : 10'h155;
            next_cycle();
        end
        chk("t4_pc0", 32'(pc_seq[0]), 32'h3FF);
        chk("t4_pc1", 32'(pc_seq[1]), 32'h000);
        chk("t4_pc2", 32'(pc_seq[2]), 32'h001);

        // Pop and redirect on the same edge with a full FIFO
        do_reset(1'b0);
        for (int c = 0; c < 3; c++) next_cycle();
        bus.dec_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 10'h100;
        @(negedge clk);
        chk("t5_head_pc", 32'({bus.dec_valid, bus.dec_pc}), 32'h400);
        next_cycle();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("t5_flushed", 32'(bus.dec_valid), 32'd0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("t5_next_pc", 32'({bus.dec_valid, bus.dec_pc}), 32'h500);
        next_cycle();

        // Asynchronous reset mid-stream
        for (int c = 0; c < 3; c++) next_cycle();
        rst_n = 1'b0;
        #2;
        chk("async_rst_valid", 32'(bus.dec_valid), 32'd0);
        chk("async_rst_opcode", 32'(bus.dec_opcode), 32'(NOP));
        chk("async_rst_rd_en", 32'(bus.imem_rd_en), 32'd0);
        chk("async_rst_pc", 32'(bus.dec_pc), 32'd0);

        // HLT at address 2
        mem[2] = {9'h1FF, 7'd2};
        do_reset(1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            opc[c] = bus.dec_opcode;
            next_cycle();
        end
        chk("t6_op_hlt", 32'(opc[4]), 32'h1FF);
        chk("t6_op_2", 32'(opc[3]), 32'd2);
`ifdef HALT_DETECT_EN
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t6_halted", 32'({bus.halted, bus.imem_rd_en, bus.dec_valid}), 32'h4);
            next_cycle();
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 10'd0;
        next_cycle();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("t6_resume", 32'({bus.halted, bus.imem_rd_en, bus.imem_addr}), 32'h400);
        next_cycle();
`else
        @(negedge clk);
        chk("t6_no_halt", 32'({bus.halted, bus.dec_valid, bus.dec_pc}), 32'h403);
        next_cycle();
`endif
        for (int c = 0; c < 4; c++) next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
